// File: rtl/bus_responder.sv
// bus_responder: decodes processor bus accesses to on-chip RAM or a 4-word I/O page
// (LED, switches, HEX value, cycle timer) and returns registered read data on DIN.
module bus_responder #(
    parameter int          RAM_AW  = 7,
    parameter logic [15:0] IO_BASE = 16'hFF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    output logic [15:0] DIN,
    input  logic [15:0] SW_in,
    output logic [15:0] LED_out,
    output logic [15:0] HEX_val,
    output logic        bus_err
);
    logic [15:0] mem [2**RAM_AW];
    logic [15:0] timer, sw_meta, sw_sync, io_data, rd_data;
    logic        ram_sel, io_sel;
    always_comb begin
        ram_sel = ADDR[15:RAM_AW] == '0;
        io_sel  = ADDR[15:2] == IO_BASE[15:2];
        io_data = ADDR[1:0] == 2'd0 ? LED_out :
                  ADDR[1:0] == 2'd1 ? sw_sync :
                  ADDR[1:0] == 2'd2 ? HEX_val : timer;
        rd_data = ram_sel ? mem[ADDR[RAM_AW-1:0]] : io_sel ? io_data : '0;
    end
    // RAM shares the reset branch so a write is never committed while reset is asserted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            DIN     <= '0;
            LED_out <= '0;
            HEX_val <= '0;
            timer   <= '0;
            bus_err <= 1'b0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            DIN     <= rd_data;
            sw_meta <= SW_in;
            sw_sync <= sw_meta;
            timer   <= (W && io_sel && ADDR[1:0] == 2'd3) ? '0 : timer + 16'd1;
            if (W && ram_sel) mem[ADDR[RAM_AW-1:0]] <= DOUT;
            if (W && io_sel && ADDR[1:0] == 2'd0) LED_out <= DOUT;
            if (W && io_sel && ADDR[1:0] == 2'd2) HEX_val <= DOUT;
            if (!ram_sel && !io_sel) bus_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: directed vector table plus randomized traffic checked against a behavioural model.
module tb_bus_responder;
    logic        clock = 1'b0;
    logic        reset, W, bus_err;
    logic [15:0] ADDR, DOUT, DIN, SW_in, LED_out, HEX_val;

    always #5 clock = ~clock;

    bus_responder dut (
        .clock(clock), .reset(reset), .ADDR(ADDR), .DOUT(DOUT), .W(W), .DIN(DIN),
        .SW_in(SW_in), .LED_out(LED_out), .HEX_val(HEX_val), .bus_err(bus_err)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] m_mem [128];
    bit          m_val [128];
    logic [15:0] m_led, m_hex;
    int          m_t;
    bit          m_err;
    logic [15:0] sw_q [$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic        w;
        bit          chk;
        logic [15:0] e;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_ram(input logic [15:0] a);
        return int'(a) < 128;
    endfunction

    function automatic bit is_io(input logic [15:0] a);
        return int'(a) >= 'hFF00 && int'(a) <= 'hFF03;
    endfunction

    task automatic model_reset();
        m_led = 0;
        m_hex = 0;
        m_t   = 0;
        m_err = 0;
        sw_q.delete();
    endtask

    task automatic check_outs();
        chk("led", LED_out, m_led);
        chk("hex", HEX_val, m_hex);
        chk("bus_err", {15'd0, bus_err}, {15'd0, m_err});
    endtask

    // one bus access: inputs are driven just after an edge, results sampled 1 unit after the next edge
    task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic w, output logic [15:0] got);
        logic [15:0] exp;
        bit known;
        ADDR = a; DOUT = d; W = w;
        known = 1;
        if (is_ram(a)) begin
            exp = m_mem[a[6:0]];
            known = m_val[a[6:0]];
        end else if (a == 16'hFF00) exp = m_led;
        else if (a == 16'hFF01) exp = (sw_q.size() == 2) ? sw_q[0] : 16'h0;
        else if (a == 16'hFF02) exp = m_hex;
        else if (a == 16'hFF03) exp = m_t[15:0];
        else exp = 16'h0;
        sw_q.push_back(SW_in);
        if (sw_q.size() > 2) void'(sw_q.pop_front());
        if (w && is_ram(a)) begin
            m_mem[a[6:0]] = d;
            m_val[a[6:0]] = 1;
        end
        if (w && a == 16'hFF00) m_led = d;
        if (w && a == 16'hFF02) m_hex = d;
        m_t = (w && a == 16'hFF03) ? 0 : m_t + 1;
        if (!is_ram(a) && !is_io(a)) m_err = 1;
        @(posedge clock);
        #1;
        got = DIN;
        if (known) chk("din_model", DIN, exp);
        check_outs();
    endtask

    task automatic reset_pulse();
        W = 0;
        reset = 1;
        #1;
        chk("rst_din", DIN, 16'h0);
        chk("rst_led", LED_out, 16'h0);
        chk("rst_hex", HEX_val, 16'h0);
        chk("rst_err", {15'd0, bus_err}, 16'h0);
        reset = 0;
        #1;
        model_reset();
    endtask

    initial begin
        logic [15:0] got, a;
        for (int i = 0; i < 128; i++) m_val[i] = 0;
        ADDR = 0; DOUT = 0; W = 0; SW_in = 16'h8001; reset = 1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("init_din", DIN, 16'h0);
        reset = 0;

        tbl.push_back('{16'h0005, 16'h1234, 1'b1, 1'b0, 16'h0});
        tbl.push_back('{16'h0006, 16'h5555, 1'b1, 1'b0, 16'h0});
        tbl.push_back('{16'h0005, 16'h0000, 1'b0, 1'b1, 16'h1234});
        tbl.push_back('{16'h0006, 16'h0000, 1'b0, 1'b1, 16'h5555});
        tbl.push_back('{16'h0005, 16'hBEEF, 1'b1, 1'b1, 16'h1234});
        tbl.push_back('{16'h0005, 16'h0000, 1'b0, 1'b1, 16'hBEEF});
        tbl.push_back('{16'hFF00, 16'h00A5, 1'b1, 1'b1, 16'h0000});
        tbl.push_back('{16'hFF00, 16'h0000, 1'b0, 1'b1, 16'h00A5});
        tbl.push_back('{16'hFF02, 16'd42,   1'b1, 1'b1, 16'h0000});
        tbl.push_back('{16'hFF02, 16'h0000, 1'b0, 1'b1, 16'd42});
        tbl.push_back('{16'hFF01, 16'hFFFF, 1'b1, 1'b1, 16'h8001});
        tbl.push_back('{16'hFF03, 16'h0000, 1'b1, 1'b0, 16'h0});
        tbl.push_back('{16'hFF03, 16'h0000, 1'b0, 1'b1, 16'd0});
        tbl.push_back('{16'hFF03, 16'h0000, 1'b0, 1'b1, 16'd1});
        tbl.push_back('{16'hFF03, 16'h0000, 1'b0, 1'b1, 16'd2});
        tbl.push_back('{16'hFF03, 16'h0000, 1'b0, 1'b1, 16'd3});
        tbl.push_back('{16'h0000, 16'h1111, 1'b1, 1'b0, 16'h0});
        tbl.push_back('{16'h007F, 16'hABCD, 1'b1, 1'b0, 16'h0});
        tbl.push_back('{16'h007F, 16'h0000, 1'b0, 1'b1, 16'hABCD});
        tbl.push_back('{16'h0200, 16'h7777, 1'b1, 1'b1, 16'h0000});
        tbl.push_back('{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h1111});
        tbl.push_back('{16'h0080, 16'h0000, 1'b0, 1'b1, 16'h0000});
        tbl.push_back('{16'hFF04, 16'h0000, 1'b0, 1'b1, 16'h0000});
        tbl.push_back('{16'hFF00, 16'h0000, 1'b0, 1'b1, 16'h00A5});
        foreach (tbl[i]) begin
            cyc(tbl[i].a, tbl[i].d, tbl[i].w, got);
            if (tbl[i].chk) chk($sformatf("vec%0d", i), got, tbl[i].e);
        end
        chk("led_after_io", LED_out, 16'h00A5);
        chk("hex_after_io", HEX_val, 16'd42);
        chk("err_sticky", {15'd0, bus_err}, 16'h1);

        // timer wrap: preload just below the wrap point
        force dut.timer = 16'hFFFE;
        #1;
        release dut.timer;
        m_t = 'hFFFE;
        cyc(16'hFF03, 16'h0, 1'b0, got); chk("wrap_fffe", got, 16'hFFFE);
        cyc(16'hFF03, 16'h0, 1'b0, got); chk("wrap_ffff", got, 16'hFFFF);
        cyc(16'hFF03, 16'h0, 1'b0, got); chk("wrap_0", got, 16'h0000);
        cyc(16'hFF03, 16'h0, 1'b0, got); chk("wrap_1", got, 16'h0001);

        reset_pulse();

        // reset held across an edge with a pending write: write must be dropped
        ADDR = 16'h0005; DOUT = 16'hDEAD; W = 1; reset = 1;
        @(posedge clock);
        #1;
        chk("abort_din", DIN, 16'h0);
        W = 0; reset = 0;
        model_reset();
        cyc(16'h0005, 16'h0, 1'b0, got); chk("abort_ram", got, 16'hBEEF);

        for (int i = 0; i < 128; i++) cyc(16'(i), 16'($urandom), 1'b1, got);
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) reset_pulse();
            if ($urandom_range(7) == 0) SW_in = 16'($urandom);
            case ($urandom_range(9))
                0, 1, 2, 3, 4, 5: a = 16'($urandom_range(127));
                6, 7, 8:          a = 16'hFF00 + 16'($urandom_range(3));
                default:          a = 16'($urandom);
            endcase
            cyc(a, 16'($urandom), 1'($urandom), got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
